hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
// Pipeline sequencer for the 5-stage RISC-V core; sits beside the forwarding logic and owns every stage-register enable.
// Inserts load-use bubbles, flushes IF/ID and ID/EX on a taken branch, and freezes the whole pipeline while data memory is busy.
// Keeps a saturating stall-cycle counter and a sticky timeout error for performance modelling and debug.
// PARAMETERS
// REGISTER_FILE_ADDRESS_WIDTH  5    width of the rs1/rs2/rd register addresses
// MEM_TIMEOUT                  64   max consecutive MEM_WAIT cycles before ERROR (>=1)
// STALL_CNT_WIDTH              32   width of stall_count
// PORTS
// clk               in   1    core clock, all state on rising edge
// rst_n             in   1    asynchronous active-low reset
// ifid_rs1          in   AW   rs1 of the instruction in ID
// ifid_rs2          in   AW   rs2 of the instruction in ID
// ifid_uses_rs1     in   1    ID instruction reads rs1
// ifid_uses_rs2     in   1    ID instruction reads rs2
// idex_rd           in   AW   destination of the instruction in EX
// idex_ctrl_mem_r   in   1    EX instruction is a load
// exmem_ctrl_mem_r  in   1    MEM instruction is a load
// exmem_ctrl_mem_w  in   1    MEM instruction is a store
// dmem_ready        in   1    data memory completes the MEM-stage access this cycle
// ex_branch_taken   in   1    EX resolved a taken branch/jump
// pc_write          out  1    PC register enable
// ifid_write        out  1    IF/ID enable
// idex_write        out  1    ID/EX enable
// exmem_write       out  1    EX/MEM enable
// ifid_flush        out  1    IF/ID loads a NOP
// idex_bubble       out  1    ID/EX loads a NOP (control bits zeroed)
// memwb_bubble      out  1    MEM/WB loads a NOP
// stall_count       out  SCW  cycles with pc_write==0 since reset, saturating
// mem_timeout_err   out  1    sticky: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
// - FSM states: INIT, RUN, MEM_WAIT, ERROR. Async reset -> INIT, wait_cnt=0, stall_count=0, mem_timeout_err=0.
// - While rst_n low and in INIT: all *_write=0, all flush/bubble=0. INIT -> RUN unconditionally after one clock.
// - mem_busy = (exmem_ctrl_mem_r | exmem_ctrl_mem_w) & ~dmem_ready.
// - load_use = idex_ctrl_mem_r & (idex_rd!=0) & ((ifid_uses_rs1 & idex_rd==ifid_rs1) | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
// - Outputs are combinational from state and inputs (zero-cycle latency). Priority in RUN/MEM_WAIT: freeze > branch > load-use.
// - Freeze (state RUN and mem_busy, or state MEM_WAIT and !dmem_ready): pc/ifid/idex/exmem_write=0, memwb_bubble=1, no flush.
// - Branch (not frozen, ex_branch_taken): all writes=1, ifid_flush=1, idex_bubble=1. A load_use in the same cycle is discarded.
// - Load-use (not frozen, no branch): pc_write=0, ifid_write=0, idex_bubble=1, idex/exmem_write=1. Exactly one bubble per hazard.
// - Otherwise: all writes=1, no flush/bubble.
// - RUN -> MEM_WAIT when mem_busy; wait_cnt loads 1.
// - MEM_WAIT: dmem_ready -> RUN (that cycle already unfrozen, wait_cnt=0); else wait_cnt++.
// - MEM_WAIT with wait_cnt==MEM_TIMEOUT and !dmem_ready -> ERROR, mem_timeout_err set.
// - ERROR: permanent freeze (as above) until rst_n; mem_timeout_err stays 1.
// - A branch held in EX during a freeze stays asserted by the frozen ID/EX; flush fires on the release cycle.
// - stall_count increments each cycle pc_write==0 in RUN/MEM_WAIT/ERROR (not INIT); holds at all-ones.
// - Reset asserted mid-wait: immediate return to INIT, counters cleared, no partial flush.
// TESTING
// - Reset, release: cycle 1 all enables 0 (INIT), cycle 2 all enables 1, stall_count=0.
// - lw x5 in EX, add x6,x5,x7 in ID -> one cycle pc_write=0,ifid_write=0,idex_bubble=1; idex_rd=0 -> no stall.
// - Store in MEM, dmem_ready low 3 cycles -> freeze 3 cycles, memwb_bubble=1, stall_count=3, 4th cycle normal.
// - ex_branch_taken with load_use same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; no extra stall next cycle.
// - MEM_TIMEOUT=4, dmem_ready held low -> ERROR after 5th wait cycle, mem_timeout_err=1, stays frozen; rst_n clears.
// - Saturation: STALL_CNT_WIDTH=3, 10 stall cycles -> stall_count holds 7.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: owns the pipeline stage enables; inserts load-use bubbles, flushes on taken
// branches, freezes on data-memory waits and tracks stall cycles plus a sticky memory timeout.
module hazard_control_unit #(
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs1,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ifid_rs2,
    input  logic                                   ifid_uses_rs1,
    input  logic                                   ifid_uses_rs2,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] idex_rd,
    input  logic                                   idex_ctrl_mem_r,
    input  logic                                   exmem_ctrl_mem_r,
    input  logic                                   exmem_ctrl_mem_w,
    input  logic                                   dmem_ready,
    input  logic                                   ex_branch_taken,
    output logic                                   pc_write,
    output logic                                   ifid_write,
    output logic                                   idex_write,
    output logic                                   exmem_write,
    output logic                                   ifid_flush,
    output logic                                   idex_bubble,
    output logic                                   memwb_bubble,
    output logic [STALL_CNT_WIDTH-1:0]             stall_count,
    output logic                                   mem_timeout_err
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int SCW = STALL_CNT_WIDTH;

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          mem_busy, load_use, active, frozen, flow;

    assign mem_busy = (exmem_ctrl_mem_r | exmem_ctrl_mem_w) & ~dmem_ready;
    assign load_use = idex_ctrl_mem_r && idex_rd != '0 &&
                      ((ifid_uses_rs1 && idex_rd == ifid_rs1) || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    assign active = state != INIT;
    assign frozen = state == ERROR || (state == RUN && mem_busy) || (state == MEM_WAIT && !dmem_ready);
    assign flow = active && !frozen;

    // A taken branch discards a simultaneous load-use stall: the dependent instruction is squashed anyway
    assign pc_write = flow && (ex_branch_taken || !load_use);
    assign ifid_write = pc_write;
    assign idex_write = flow;
    assign exmem_write = flow;
    assign ifid_flush = flow && ex_branch_taken;
    assign idex_bubble = flow && (ex_branch_taken || load_use);
    assign memwb_bubble = frozen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            wait_cnt <= '0;
            stall_count <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if (active && !pc_write && stall_count != '1)
                stall_count <= stall_count + SCW'(1);
            case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (mem_busy) begin
                        state <= MEM_WAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
                        state <= ERROR;
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ERROR: mem_timeout_err <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scenarios then randomized traffic, each cycle checked against
// a cycle-counting reference model of the hazard rules.
module tb_hazard_control_unit;
    localparam int AW = 5;
    localparam int T = 4;
    localparam int SCW = 3;
    localparam int SMAX = (1 << SCW) - 1;
    localparam logic [6:0] NORM = 7'b1111000;
    localparam logic [6:0] LU = 7'b0011010;
    localparam logic [6:0] BR = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [AW-1:0] ifid_rs1, ifid_rs2, idex_rd;
    logic ifid_uses_rs1, ifid_uses_rs2, idex_ctrl_mem_r, exmem_ctrl_mem_r, exmem_ctrl_mem_w;
    logic dmem_ready, ex_branch_taken;
    logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble;
    logic [SCW-1:0] stall_count;
    logic mem_timeout_err;
    logic [6:0] outs;

    int tests = 0;
    int fails = 0;
    bit m_init = 1'b1;
    bit m_err = 1'b0;
    int m_waited = 0;
    int m_stalls = 0;
    logic [6:0] obs_out;
    logic [SCW-1:0] obs_stall;
    logic obs_err;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .REGISTER_FILE_ADDRESS_WIDTH(AW),
        .MEM_TIMEOUT(T),
        .STALL_CNT_WIDTH(SCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1),
        .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd),
        .idex_ctrl_mem_r(idex_ctrl_mem_r),
        .exmem_ctrl_mem_r(exmem_ctrl_mem_r),
        .exmem_ctrl_mem_w(exmem_ctrl_mem_w),
        .dmem_ready(dmem_ready),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .idex_write(idex_write),
        .exmem_write(exmem_write),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble),
        .stall_count(stall_count),
        .mem_timeout_err(mem_timeout_err)
    );

    assign outs = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic u1, input logic u2,
                         input logic [AW-1:0] rd, input logic ld, input logic mr, input logic mw,
                         input logic rdy, input logic br);
        ifid_rs1 = rs1;
        ifid_rs2 = rs2;
        ifid_uses_rs1 = u1;
        ifid_uses_rs2 = u2;
        idex_rd = rd;
        idex_ctrl_mem_r = ld;
        exmem_ctrl_mem_r = mr;
        exmem_ctrl_mem_w = mw;
        dmem_ready = rdy;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // One clock: check mid-cycle against the model, then advance the model across the edge
    task automatic step(input string tag);
        logic hz, frz, run;
        logic [6:0] exp;
        #3;
        if (!rst_n) begin
            m_init = 1'b1;
            m_err = 1'b0;
            m_waited = 0;
            m_stalls = 0;
        end
        hz = idex_ctrl_mem_r && idex_rd != 0 &&
             ((ifid_uses_rs1 && idex_rd == ifid_rs1) || (ifid_uses_rs2 && idex_rd == ifid_rs2));
        frz = !m_init && (m_err || (!dmem_ready && (m_waited > 0 || exmem_ctrl_mem_r || exmem_ctrl_mem_w)));
        run = !m_init && !frz;
        exp = {run && (ex_branch_taken || !hz), run && (ex_branch_taken || !hz), run, run,
               run && ex_branch_taken, run && (ex_branch_taken || hz), frz};
        obs_out = outs;
        obs_stall = stall_count;
        obs_err = mem_timeout_err;
        check({tag, "_out"}, 32'(obs_out), 32'(exp));
        check({tag, "_cnt"}, 32'(obs_stall), m_stalls);
        check({tag, "_err"}, 32'(obs_err), 32'(m_err));
        @(posedge clk);
        if (rst_n && !m_init) begin
            if (!exp[6]) m_stalls = m_stalls < SMAX ? m_stalls + 1 : SMAX;
            if (!frz) m_waited = 0;
            else if (!m_err) begin
                m_waited++;
                if (m_waited == T + 1) m_err = 1'b1;
            end
        end else if (rst_n) begin
            m_init = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step("rst");
        check("rst_out", 32'(obs_out), 32'(0));
        rst_n = 1'b1;
        step("init");
        check("init_out", 32'(obs_out), 32'(0));
    endtask

    initial begin
        idle();
        #1;
        do_reset();
        step("run");
        check("run_out", 32'(obs_out), 32'(NORM));
        check("run_cnt", 32'(obs_stall), 32'(0));

        drive(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu");
        check("lu_out", 32'(obs_out), 32'(LU));
        idle();
        step("lu_after");
        check("lu_after_out", 32'(obs_out), 32'(NORM));
        drive(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_x0");
        check("lu_x0_out", 32'(obs_out), 32'(NORM));

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step("st_wait");
            check("st_wait_out", 32'(obs_out), 32'(FRZ));
        end
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("st_done");
        check("st_done_out", 32'(obs_out), 32'(NORM));
        check("st_done_cnt", 32'(obs_stall), 32'(3));

        drive(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("br_lu");
        check("br_lu_out", 32'(obs_out), 32'(BR));
        idle();
        step("br_after");
        check("br_after_out", 32'(obs_out), 32'(NORM));
        check("br_after_cnt", 32'(obs_stall), 32'(3));

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step("to_wait");
            check("to_wait_err", 32'(obs_err), 32'(0));
        end
        step("to_err");
        check("to_err_err", 32'(obs_err), 32'(1));
        check("to_err_out", 32'(obs_out), 32'(FRZ));
        idle();
        step("to_hold");
        check("to_hold_out", 32'(obs_out), 32'(FRZ));
        check("to_hold_err", 32'(obs_err), 32'(1));
        do_reset();
        step("to_clr");
        check("to_clr_err", 32'(obs_err), 32'(0));
        check("to_clr_out", 32'(obs_out), 32'(NORM));

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step("sat");
        end
        idle();
        step("sat_end");
        check("sat_cnt", 32'(obs_stall), 32'(SMAX));

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_wait");
        step("mid_wait");
        rst_n = 1'b0;
        step("mid_rst");
        check("mid_rst_out", 32'(obs_out), 32'(0));
        check("mid_rst_cnt", 32'(obs_stall), 32'(0));
        rst_n = 1'b1;
        idle();
        step("mid_init");

        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 199) != 0;
            drive(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 6) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
